// File: rtl/fdivsqrt_seq_if.sv
// IU <-> FPU issue / writeback bundle for the iterative divide / square-root unit.
// The IU side drives the issue strobe and operands; the FPU side returns status and result.
interface fdivsqrt_seq_if;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd_in;
  logic        cancel;
  logic        busy;
  logic [4:0]  count;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd;
  logic        dz;
  logic        nv;

  modport master (output start, op, a, b, rd_in, cancel,
                  input  busy, count, done, result, rd, dz, nv);
  modport slave  (input  start, op, a, b, rd_in, cancel,
                  output busy, count, done, result, rd, dz, nv);
endinterface

// File: rtl/fdivsqrt_seq.sv
// Iterative single-precision fdiv / fsqrt: one quotient/root bit per cycle,
// round-to-nearest-even, denormals flushed to zero on input and output.
module fdivsqrt_seq #(
  parameter logic [31:0] QNAN = 32'h7FC00000
) (
  input  logic          clock,
  input  logic          resetn,
  fdivsqrt_seq_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_ROUND} state_t;

  state_t             r_state;
  logic [4:0]         r_cnt;
  logic               r_done;
  logic [31:0]        r_result;
  logic [4:0]         r_rd;
  logic               r_dz;
  logic               r_nv;

  logic               r_op;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [4:0]         r_rd_cap;
  logic [23:0]        r_dvsr;
  logic [27:0]        r_rem;
  logic [25:0]        r_q;
  logic [49:0]        r_rad;
  logic               r_spec;
  logic [31:0]        r_spec_res;
  logic               r_spec_dz;
  logic               r_spec_nv;

  function automatic logic [31:0] round_pack(input logic              sign,
                                             input logic signed [9:0] exp_in,
                                             input logic [23:0]       mant,
                                             input logic              guard,
                                             input logic              sticky);
    logic              up;
    logic [24:0]       sum;
    logic signed [9:0] e;
    logic [22:0]       frac;
    up   = guard & (sticky | mant[0]);
    sum  = {1'b0, mant} + {24'd0, up};
    e    = sum[24] ? exp_in + 10'sd1 : exp_in;
    frac = sum[24] ? 23'd0 : sum[22:0];
    if (e >= 10'sd255)    round_pack = {sign, 8'hFF, 23'd0};
    else if (e <= 10'sd0) round_pack = {sign, 31'd0};
    else                  round_pack = {sign, e[7:0], frac};
  endfunction

  logic [7:0]        w_ea, w_eb;
  logic [22:0]       w_fa, w_fb;
  logic              w_sa, w_sb;
  logic              w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
  logic [23:0]       w_ma, w_mb;
  logic signed [9:0] w_ea_unb, w_exp_div, w_exp_sqrt;
  logic [49:0]       w_rad;
  logic              w_accept;

  assign w_sa     = bus.a[31];
  assign w_ea     = bus.a[30:23];
  assign w_fa     = bus.a[22:0];
  assign w_sb     = bus.b[31];
  assign w_eb     = bus.b[30:23];
  assign w_fb     = bus.b[22:0];
  // A zero exponent means zero or denormal; both are treated as signed zero.
  assign w_a_zero = (w_ea == 8'h00);
  assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'd0);
  assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'd0);
  assign w_b_zero = (w_eb == 8'h00);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'd0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'd0);
  assign w_ma     = {1'b1, w_fa};
  assign w_mb     = {1'b1, w_fb};

  assign w_ea_unb   = $signed({2'b00, w_ea}) - 10'sd127;
  assign w_exp_div  = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 10'sd127;
  assign w_exp_sqrt = (w_ea_unb >>> 1) + 10'sd127;
  // Odd exponent: double the radicand so the remaining exponent halves exactly.
  assign w_rad      = w_ea_unb[0] ? {w_ma, 26'd0} : {1'b0, w_ma, 25'd0};
  assign w_accept   = (r_state == ST_IDLE) && bus.start && !bus.cancel;

  logic        w_spec;
  logic [31:0] w_spec_res;
  logic        w_spec_dz;
  logic        w_spec_nv;

  always_comb begin
    w_spec     = 1'b1;
    w_spec_res = QNAN;
    w_spec_dz  = 1'b0;
    w_spec_nv  = 1'b0;
    if (!bus.op) begin
      if (w_a_nan || w_b_nan)                          w_spec_res = QNAN;
      else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) w_spec_nv = 1'b1;
      else if (w_a_inf)                                w_spec_res = {w_sa ^ w_sb, 8'hFF, 23'd0};
      else if (w_b_zero) begin
        w_spec_res = {w_sa ^ w_sb, 8'hFF, 23'd0};
        w_spec_dz  = 1'b1;
      end
      else if (w_b_inf || w_a_zero)                    w_spec_res = {w_sa ^ w_sb, 31'd0};
      else                                             w_spec = 1'b0;
    end else begin
      if (w_a_nan)                  w_spec_res = QNAN;
      else if (w_sa && !w_a_zero)   w_spec_nv  = 1'b1;
      else if (w_a_zero)            w_spec_res = {w_sa, 31'd0};
      else if (w_a_inf)             w_spec_res = {1'b0, 8'hFF, 23'd0};
      else                          w_spec = 1'b0;
    end
  end

  logic [27:0] w_dvsr_ext, w_div_rem_nxt, w_sq_rem, w_sq_trial, w_sq_rem_nxt;
  logic        w_div_bit, w_sq_bit;

  assign w_dvsr_ext    = {4'd0, r_dvsr};
  assign w_div_bit     = (r_rem >= w_dvsr_ext);
  assign w_div_rem_nxt = (w_div_bit ? r_rem - w_dvsr_ext : r_rem) << 1;
  assign w_sq_rem      = {r_rem[25:0], r_rad[49:48]};
  assign w_sq_trial    = {1'b0, r_q[24:0], 2'b01};
  assign w_sq_bit      = (w_sq_rem >= w_sq_trial);
  assign w_sq_rem_nxt  = w_sq_bit ? w_sq_rem - w_sq_trial : w_sq_rem;

  logic [23:0]       w_mant;
  logic              w_guard;
  logic              w_sticky;
  logic signed [9:0] w_exp_rnd;
  logic [31:0]       w_round_res;

  // Quotient below 1.0 needs one left shift; the root is always in [1,2).
  always_comb begin
    w_mant    = r_q[24:1];
    w_guard   = r_q[0];
    w_sticky  = |r_rem;
    w_exp_rnd = r_exp;
    if (!r_op) begin
      if (r_q[25]) begin
        w_mant   = r_q[25:2];
        w_guard  = r_q[1];
        w_sticky = r_q[0] | (|r_rem);
      end else begin
        w_exp_rnd = r_exp - 10'sd1;
      end
    end
  end

  assign w_round_res = round_pack(r_sign, w_exp_rnd, w_mant, w_guard, w_sticky);

  // Control and architectural outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 5'd0;
      r_done   <= 1'b0;
      r_result <= 32'h0;
      r_rd     <= 5'h0;
      r_dz     <= 1'b0;
      r_nv     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_spec) begin
              r_state <= ST_ROUND;
              r_cnt   <= 5'd0;
            end else begin
              r_state <= ST_ITER;
              r_cnt   <= bus.op ? 5'd25 : 5'd26;
            end
          end
        end
        ST_ITER: begin
          if (bus.cancel) begin
            r_state <= ST_IDLE;
            r_cnt   <= 5'd0;
          end else begin
            r_cnt <= r_cnt - 5'd1;
            if (r_cnt == 5'd1) r_state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          r_state <= ST_IDLE;
          r_cnt   <= 5'd0;
          if (!bus.cancel) begin
            r_done   <= 1'b1;
            r_result <= r_spec ? r_spec_res : w_round_res;
            r_rd     <= r_rd_cap;
            r_dz     <= r_spec & r_spec_dz;
            r_nv     <= r_spec & r_spec_nv;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 5'd0;
        end
      endcase
    end
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_op       <= bus.op;
      r_rd_cap   <= bus.rd_in;
      r_sign     <= bus.op ? w_sa : (w_sa ^ w_sb);
      r_exp      <= bus.op ? w_exp_sqrt : w_exp_div;
      r_dvsr     <= w_mb;
      r_rem      <= bus.op ? 28'd0 : {4'd0, w_ma};
      r_q        <= 26'd0;
      r_rad      <= w_rad;
      r_spec     <= w_spec;
      r_spec_res <= w_spec_res;
      r_spec_dz  <= w_spec_dz;
      r_spec_nv  <= w_spec_nv;
    end else if (r_state == ST_ITER) begin
      r_rem <= r_op ? w_sq_rem_nxt : w_div_rem_nxt;
      r_q   <= {r_q[24:0], (r_op ? w_sq_bit : w_div_bit)};
      r_rad <= {r_rad[47:0], 2'b00};
    end
  end

  assign bus.busy   = (r_state != ST_IDLE);
  assign bus.count  = r_cnt;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.rd     = r_rd;
  assign bus.dz     = r_dz;
  assign bus.nv     = r_nv;

endmodule

// File: tb/tb_fdivsqrt_seq.sv
// Bench for fdivsqrt_seq: directed corner cases plus random fdiv/fsqrt traffic
// compared against an integer-arithmetic reference model.
module tb_fdivsqrt_seq;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  fdivsqrt_seq_if u_if();

  fdivsqrt_seq #(.QNAN(32'h7FC00000)) dut (
    .clock  (clk),
    .resetn (resetn),
    .bus    (u_if)
  );

  localparam logic [31:0] QNAN = 32'h7FC00000;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] res;
    logic        dz;
    logic        nv;
    logic        spec;
  } ref_t;

  function automatic logic [31:0] ref_pack(input logic sign, input int e, input longint m,
                                           input bit g, input bit s);
    if (g && (s || m[0])) m = m + 1;
    if (m == 64'd16777216) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {sign, 8'hFF, 23'd0};
    if (e <= 0)   return {sign, 31'd0};
    return {sign, 8'(e), m[22:0]};
  endfunction

  function automatic ref_t ref_model(input logic op, input logic [31:0] a, input logic [31:0] b);
    ref_t   r;
    int     ea, eb, e, k;
    bit     sa, sb, az, ai, an, bz, bi, bn;
    longint ma, mb, q, rm, n, rt;
    sa = a[31]; sb = b[31];
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    az = (ea == 0); ai = (ea == 255) && (a[22:0] == 0); an = (ea == 255) && (a[22:0] != 0);
    bz = (eb == 0); bi = (eb == 255) && (b[22:0] == 0); bn = (eb == 255) && (b[22:0] != 0);
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    r.res = QNAN; r.dz = 1'b0; r.nv = 1'b0; r.spec = 1'b1;
    if (!op) begin
      if (an || bn)                      r.res = QNAN;
      else if ((az && bz) || (ai && bi)) r.nv = 1'b1;
      else if (ai)                       r.res = {sa ^ sb, 8'hFF, 23'd0};
      else if (bz) begin
        r.res = {sa ^ sb, 8'hFF, 23'd0};
        r.dz  = 1'b1;
      end
      else if (bi || az)                 r.res = {sa ^ sb, 31'd0};
      else begin
        r.spec = 1'b0;
        q  = (ma << 26) / mb;
        rm = (ma << 26) % mb;
        if (q >= (64'sd1 << 26))
          r.res = ref_pack(sa ^ sb, ea - eb + 127, q >> 3, q[2], (q[1:0] != 0) || (rm != 0));
        else
          r.res = ref_pack(sa ^ sb, ea - eb + 126, q >> 2, q[1], q[0] || (rm != 0));
      end
    end else begin
      if (an)              r.res = QNAN;
      else if (sa && !az)  r.nv = 1'b1;
      else if (az)         r.res = {sa, 31'd0};
      else if (ai)         r.res = {1'b0, 8'hFF, 23'd0};
      else begin
        r.spec = 1'b0;
        e = ea - 127;
        if ((e & 1) != 0) begin n = ma << 26; k = (e - 1) / 2; end
        else              begin n = ma << 25; k = e / 2;       end
        rt = longint'($sqrt(real'(n)));
        while (rt * rt > n) rt--;
        while ((rt + 1) * (rt + 1) <= n) rt++;
        r.res = ref_pack(1'b0, k + 127, rt >> 1, rt[0], (rt * rt) != n);
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_fp();
    int          k;
    logic [31:0] v;
    k = $urandom_range(0, 19);
    v = $urandom;
    case (k)
      0: v[30:0] = 31'd0;
      1: v[30:0] = {8'hFF, 23'd0};
      2: begin v[30:23] = 8'hFF; if (v[22:0] == 23'd0) v[0] = 1'b1; end
      3: v[30:23] = 8'h00;
      4, 5, 6: v[30:23] = 8'($urandom_range(1, 254));
      default: v[30:23] = 8'($urandom_range(112, 142));
    endcase
    return v;
  endfunction

  // Issues one operation in the current cycle and follows it to done.
  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int poke_at, input string tag);
    ref_t r;
    int   lat;
    int   init;
    r    = ref_model(op, a, b);
    init = r.spec ? 0 : (op ? 25 : 26);
    u_if.start = 1'b1; u_if.op = op; u_if.a = a; u_if.b = b; u_if.rd_in = rd;
    @(negedge clk);
    u_if.start = 1'b0; u_if.op = 1'($urandom); u_if.a = $urandom; u_if.b = $urandom;
    u_if.rd_in = 5'($urandom);
    lat = 0;
    while (!u_if.done && lat < 40) begin
      check_eq({tag, ".busy"}, u_if.busy, 32'd1);
      check_eq({tag, ".count"}, u_if.count, (init - lat > 0) ? init - lat : 0);
      if (lat == poke_at) begin
        u_if.start = 1'b1;
        u_if.a     = 32'h41200000;
        u_if.b     = 32'h3F800000;
      end
      @(negedge clk);
      u_if.start = 1'b0;
      lat++;
    end
    check_eq({tag, ".latency"}, lat, init + 1);
    check_eq({tag, ".done"}, u_if.done, 32'd1);
    check_eq({tag, ".busy_done"}, u_if.busy, 32'd0);
    check_eq({tag, ".result"}, u_if.result, r.res);
    check_eq({tag, ".rd"}, u_if.rd, rd);
    check_eq({tag, ".dz"}, u_if.dz, r.dz);
    check_eq({tag, ".nv"}, u_if.nv, r.nv);
  endtask

  task automatic run_cancel(input logic op, input logic [31:0] a, input logic [31:0] b,
                            input int cancel_at, input string tag);
    logic [31:0] prev_res;
    logic [4:0]  prev_rd;
    int          init;
    bit          seen;
    prev_res = u_if.result;
    prev_rd  = u_if.rd;
    init     = op ? 25 : 26;
    u_if.start = 1'b1; u_if.op = op; u_if.a = a; u_if.b = b; u_if.rd_in = 5'd31;
    @(negedge clk);
    u_if.start = 1'b0;
    repeat (cancel_at) @(negedge clk);
    check_eq({tag, ".count_pre"}, u_if.count, (init - cancel_at > 0) ? init - cancel_at : 0);
    check_eq({tag, ".busy_pre"}, u_if.busy, 32'd1);
    u_if.cancel = 1'b1;
    @(negedge clk);
    u_if.cancel = 1'b0;
    check_eq({tag, ".busy_post"}, u_if.busy, 32'd0);
    check_eq({tag, ".count_post"}, u_if.count, 32'd0);
    seen = 1'b0;
    repeat (35) begin
      if (u_if.done) seen = 1'b1;
      @(negedge clk);
    end
    check_eq({tag, ".no_done"}, seen, 32'd0);
    check_eq({tag, ".result_held"}, u_if.result, prev_res);
    check_eq({tag, ".rd_held"}, u_if.rd, prev_rd);
  endtask

  initial begin
    u_if.start = 1'b0; u_if.op = 1'b0; u_if.a = 32'h0; u_if.b = 32'h0;
    u_if.rd_in = 5'h0; u_if.cancel = 1'b0;
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst.busy",   u_if.busy,   32'd0);
    check_eq("rst.done",   u_if.done,   32'd0);
    check_eq("rst.count",  u_if.count,  32'd0);
    check_eq("rst.result", u_if.result, 32'd0);
    check_eq("rst.rd",     u_if.rd,     32'd0);
    check_eq("rst.dz",     u_if.dz,     32'd0);
    check_eq("rst.nv",     u_if.nv,     32'd0);
    resetn = 1'b1;
    @(negedge clk);

    run_op(1'b0, 32'h40C00000, 32'h40000000, 5'd3, -1, "div6_2");
    check_eq("div6_2.const", u_if.result, 32'h40400000);
    run_op(1'b0, 32'h3F800000, 32'h40400000, 5'd4, -1, "div1_3");
    check_eq("div1_3.const", u_if.result, 32'h3EAAAAAB);
    run_op(1'b1, 32'h40000000, 32'h0, 5'd5, -1, "sqrt2");
    check_eq("sqrt2.const", u_if.result, 32'h3FB504F3);
    run_op(1'b1, 32'h40800000, 32'h0, 5'd6, -1, "sqrt4");
    check_eq("sqrt4.const", u_if.result, 32'h40000000);
    run_op(1'b0, 32'h3F800000, 32'h00000000, 5'd7, -1, "div_by0");
    check_eq("div_by0.const", u_if.result, 32'h7F800000);
    check_eq("div_by0.dz_const", u_if.dz, 32'd1);
    run_op(1'b0, 32'h00000000, 32'h00000000, 5'd8, -1, "div0_0");
    check_eq("div0_0.const", u_if.result, QNAN);
    check_eq("div0_0.nv_const", u_if.nv, 32'd1);
    run_op(1'b1, 32'hBF800000, 32'h0, 5'd9, -1, "sqrt_neg");
    check_eq("sqrt_neg.const", u_if.result, QNAN);
    check_eq("sqrt_neg.nv_const", u_if.nv, 32'd1);
    run_op(1'b0, 32'h7F000000, 32'h00800000, 5'd10, -1, "div_ovf");
    check_eq("div_ovf.const", u_if.result, 32'h7F800000);
    run_op(1'b0, 32'h00800000, 32'h7F000000, 5'd11, -1, "div_unf");
    check_eq("div_unf.const", u_if.result, 32'h00000000);
    run_op(1'b0, 32'h40C00000, 32'h40000000, 5'd12, 5, "start_busy");
    check_eq("start_busy.const", u_if.result, 32'h40400000);

    run_cancel(1'b0, 32'h40490FDB, 32'h402DF854, 16, "cancel10");
    run_cancel(1'b0, 32'h40490FDB, 32'h402DF854, 26, "cancel_round");
    run_cancel(1'b1, 32'h40490FDB, 32'h0, 7, "cancel_sqrt");

    u_if.start = 1'b1; u_if.cancel = 1'b1; u_if.op = 1'b0;
    u_if.a = 32'h40C00000; u_if.b = 32'h40000000;
    @(negedge clk);
    u_if.start = 1'b0; u_if.cancel = 1'b0;
    check_eq("idle_cancel.busy", u_if.busy, 32'd0);
    @(negedge clk);
    check_eq("idle_cancel.done", u_if.done, 32'd0);

    u_if.start = 1'b1; u_if.op = 1'b0; u_if.a = 32'h40C00000; u_if.b = 32'h40000000;
    u_if.rd_in = 5'd21;
    @(negedge clk);
    u_if.start = 1'b0;
    repeat (21) @(negedge clk);
    check_eq("rst_mid.count_pre", u_if.count, 32'd5);
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_mid.busy",   u_if.busy,   32'd0);
    check_eq("rst_mid.count",  u_if.count,  32'd0);
    check_eq("rst_mid.done",   u_if.done,   32'd0);
    check_eq("rst_mid.result", u_if.result, 32'd0);
    check_eq("rst_mid.rd",     u_if.rd,     32'd0);
    check_eq("rst_mid.dz",     u_if.dz,     32'd0);
    check_eq("rst_mid.nv",     u_if.nv,     32'd0);
    @(negedge clk);
    resetn = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      repeat (30) begin
        @(negedge clk);
        if (u_if.done || u_if.busy) seen = 1'b1;
      end
      check_eq("rst_mid.quiet", seen, 32'd0);
    end

    for (int i = 0; i < 300; i++) begin
      logic        op;
      logic [31:0] a, b;
      int          gap;
      op = 1'($urandom);
      a  = rand_fp();
      b  = rand_fp();
      if (op && ($urandom_range(0, 3) != 0)) a[31] = 1'b0;
      run_op(op, a, b, 5'($urandom), -1, op ? "rnd_sqrt" : "rnd_div");
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(negedge clk);
        check_eq("rnd.done_pulse", u_if.done, 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
